// File: rtl/alu_serial_seq_if.sv
// Request/response handshake bundle for the bit-serial ALU sequencer.
// master = requester/consumer side, slave = sequencer side.
interface alu_serial_seq_if #(
  parameter int WIDTH = 8
);
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             req_cin;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic             res_cout;
  logic             res_zero;
  logic             res_err;

  modport master (
    output req_valid, req_op, req_a, req_b, req_cin, res_ready,
    input  req_ready, res_valid, res_data, res_cout, res_zero, res_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_cin, res_ready,
    output req_ready, res_valid, res_data, res_cout, res_zero, res_err
  );
endinterface

// File: rtl/alu_serial_seq.sv
// Bit-serial sequencer feeding a 1-bit ALU slice, LSB first.
// Define SERIAL_SUB_EN to enable op 6 (SUB, A - B).
module alu_serial_seq #(
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_serial_seq_if.slave bus,
  output logic [7:0]  alu_m,
  output logic        alu_a,
  output logic        alu_b,
  output logic        alu_c,
  input  logic        alu_out,
  input  logic        alu_next
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] r_sh;
  logic [CW-1:0]    cnt;
  logic [7:0]       mode;
  logic             arith;
  logic             inv_b;
  logic             carry;
  logic             cout_q;
  logic             zero_q;
  logic             err_q;

  logic [7:0]       dec_mode;
  logic             dec_arith;
  logic             dec_inv;
  logic             dec_cin;
  logic             dec_legal;
  logic [WIDTH-1:0] r_next;
  logic             run;

  always_comb begin
    dec_mode  = 8'h00;
    dec_arith = 1'b0;
    dec_inv   = 1'b0;
    dec_cin   = 1'b0;
    dec_legal = 1'b1;
    unique case (1'b1)
      bus.req_op == 3'd0: begin
        dec_mode  = 8'h01;
        dec_arith = 1'b1;
      end
      bus.req_op == 3'd1: begin
        dec_mode  = 8'h01;
        dec_arith = 1'b1;
        dec_cin   = bus.req_cin;
      end
      bus.req_op == 3'd2: dec_mode = 8'h02;
      bus.req_op == 3'd3: dec_mode = 8'h04;
      bus.req_op == 3'd4: dec_mode = 8'h08;
      bus.req_op == 3'd5: dec_mode = 8'h10;
`ifdef SERIAL_SUB_EN
      bus.req_op == 3'd6: begin
        dec_mode  = 8'h01;
        dec_arith = 1'b1;
        dec_inv   = 1'b1;
        dec_cin   = 1'b1;
      end
`endif
      default: dec_legal = 1'b0;
    endcase
  end

  assign run    = (state == RUN);
  assign r_next = {alu_out, r_sh[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      r_sh   <= '0;
      cnt    <= '0;
      mode   <= '0;
      arith  <= 1'b0;
      inv_b  <= 1'b0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
      zero_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.req_valid) begin
            a_sh   <= bus.req_a;
            b_sh   <= bus.req_b;
            r_sh   <= '0;
            cnt    <= '0;
            mode   <= dec_mode;
            arith  <= dec_arith;
            inv_b  <= dec_inv;
            carry  <= dec_cin;
            cout_q <= 1'b0;
            zero_q <= 1'b0;
            err_q  <= ~dec_legal;
            state  <= dec_legal ? RUN : DONE;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          r_sh  <= r_next;
          // logic modes never propagate a carry into the next bit
          carry <= arith & alu_next;
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            cout_q <= arith & alu_next;
            zero_q <= (r_next == '0);
            state  <= DONE;
          end
        end
        DONE: begin
          if (bus.res_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.res_valid = (state == DONE);
  assign bus.res_data  = r_sh;
  assign bus.res_cout  = cout_q;
  assign bus.res_zero  = zero_q;
  assign bus.res_err   = err_q;

  assign alu_m = run ? mode : 8'h00;
  assign alu_a = run & a_sh[0];
  assign alu_b = run & (b_sh[0] ^ inv_b);
  assign alu_c = run & carry;

endmodule
